// File: rtl/ro_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the ring-oscillator entropy source: synchronizer depth,
// per-channel ring length and the mode/state encodings used by the top level.
package ro_pkg;

  localparam int RO_SYNC_STAGES = 2;

  typedef enum logic {
    DEBIAS_RAW,
    DEBIAS_VN
  } debias_mode_e;

  typedef enum logic {
    HEALTH_OK,
    HEALTH_FAIL
  } health_state_e;

  // Rings differ by two inverters per channel so every ring stays odd-length
  // and no two channels share a frequency.
  function automatic int stages_of(input int base, input int idx);
    return base + 2 * idx;
  endfunction

endpackage

// File: rtl/ro_cell.sv
`timescale 1ns/1ps
// One gated inverter ring. With en low the ring input is held at 0 and the
// output is gated to 0; R_OSC_SYNTHESIS selects the delay-free combinational ring.
module ro_cell #(
  parameter int STAGES       = 3,
  parameter int INV_DELAY_ns = 2
) (
  input  logic en,
  output logic clk_out
);

  logic [STAGES-1:0] stage;

`ifndef R_OSC_SYNTHESIS
  // Settled state of the chain when its input is held at 0: inverter k outputs 1 for even k.
  localparam logic [STAGES-1:0] IDLE_PATTERN = STAGES'({((STAGES + 1) / 2){2'b01}});

  // Every inverter switches one delay after its input; stepping the whole chain
  // once per delay is exact for equal-delay inverters.
  always begin
    #(INV_DELAY_ns);
    if (en)
      stage = {~stage[STAGES-2:0], ~stage[STAGES-1]};
    else
      stage = IDLE_PATTERN;
  end
`else
  assign stage[0] = ~(en & stage[STAGES-1]);
  for (genvar k = 1; k < STAGES; k++) begin : g_inv
    assign stage[k] = ~stage[k-1];
  end
`endif

  assign clk_out = en & stage[STAGES-1];

endmodule

// File: rtl/ro_entropy_source.sv
`timescale 1ns/1ps
// Multi-channel ring-oscillator entropy source: synchronized rings XORed into one raw
// bit, optional von Neumann debias, word packer on valid/ready, sticky repetition test.
module ro_entropy_source
  import ro_pkg::*;
#(
  parameter int NO_CHANNELS  = 4,
  parameter int NO_STAGES    = 3,
  parameter int INV_DELAY_ns = 2,
  parameter int SAMPLE_DIV   = 8,
  parameter int WORD_W       = 32,
  parameter int REP_LIMIT    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              vn_en,
  input  logic              rdy_in,
  output logic [WORD_W-1:0] data_out,
  output logic              valid_out,
  output logic              health_fail
);

  localparam int DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam int REP_W = $clog2(REP_LIMIT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] WORD_FULL = CNT_W'(WORD_W);
  localparam logic [REP_W-1:0] REP_MAX   = REP_W'(REP_LIMIT);

  logic [NO_CHANNELS-1:0] ring_out;
  logic [NO_CHANNELS-1:0] ring_sync;
  logic                   raw_bit;

  // Rings and their 2-FF synchronizers
  for (genvar c = 0; c < NO_CHANNELS; c++) begin : g_ch
    logic [RO_SYNC_STAGES-1:0] sync_pipe;

    ro_cell #(
      .STAGES      (stages_of(NO_STAGES, c)),
      .INV_DELAY_ns(INV_DELAY_ns)
    ) u_ring (
      .en     (en),
      .clk_out(ring_out[c])
    );

    always_ff @(posedge clk)
      sync_pipe <= {sync_pipe[RO_SYNC_STAGES-2:0], ring_out[c]};

    assign ring_sync[c] = sync_pipe[RO_SYNC_STAGES-1];
  end

  assign raw_bit = ^ring_sync;

  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  debias_mode_e      mode;
  logic              vn_prev;
  logic              vn_change;
  logic              pair_vld_p1;
  logic              pair_bit_p1;
  logic [WORD_W-1:0] shreg_p1;
  logic [CNT_W-1:0]  bitcnt_p1;
  logic [REP_W-1:0]  rep_cnt_p1;
  logic [REP_W-1:0]  rep_next;
  logic              last_raw_p1;
  logic              emit;
  logic              emit_bit;
  logic              word_done;
  logic              xfer;
  logic              health_trip;
  health_state_e     health_state;

  assign tick      = en && (div_cnt == DIV_LAST);
  assign mode      = vn_en ? DEBIAS_VN : DEBIAS_RAW;
  assign vn_change = (vn_en != vn_prev);
  assign word_done = (bitcnt_p1 == WORD_FULL);
  assign xfer      = valid_out && rdy_in;

  // Sample stage: debias decision; a 10 pair yields 1, 01 yields 0, i.e. the first bit.
  always_comb begin
    emit     = 1'b0;
    emit_bit = raw_bit;
    if (tick) begin
      if (mode == DEBIAS_RAW) begin
        emit = 1'b1;
      end else if (pair_vld_p1 && (pair_bit_p1 != raw_bit)) begin
        emit     = 1'b1;
        emit_bit = pair_bit_p1;
      end
    end
  end

  always_comb begin
    rep_next = rep_cnt_p1;
    if ((rep_cnt_p1 == '0) || (raw_bit != last_raw_p1))
      rep_next = REP_W'(1);
    else if (rep_cnt_p1 < REP_MAX)
      rep_next = rep_cnt_p1 + 1'b1;
  end

  assign health_trip = tick && (rep_next == REP_MAX);

  always_ff @(posedge clk) begin
    if (rst)
      vn_prev <= 1'b0;
    else
      vn_prev <= vn_en;
  end

  // Collection stage: divider, pair register, packer and repetition counter
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_cnt     <= '0;
      pair_vld_p1 <= 1'b0;
      pair_bit_p1 <= 1'b0;
      shreg_p1    <= '0;
      bitcnt_p1   <= '0;
      rep_cnt_p1  <= '0;
      last_raw_p1 <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;

      if (tick) begin
        rep_cnt_p1  <= rep_next;
        last_raw_p1 <= raw_bit;
      end

      if (vn_change) begin
        pair_vld_p1 <= 1'b0;
      end else if (tick && (mode == DEBIAS_VN)) begin
        pair_vld_p1 <= !pair_vld_p1;
        if (!pair_vld_p1)
          pair_bit_p1 <= raw_bit;
      end

      // A completed word always restarts collection, whether it is taken or dropped.
      if (word_done) begin
        bitcnt_p1 <= '0;
      end else if (emit) begin
        shreg_p1  <= {shreg_p1[WORD_W-2:0], emit_bit};
        bitcnt_p1 <= bitcnt_p1 + 1'b1;
      end
    end
  end

  // Output stage: a word loads only when the port is empty or being emptied this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (health_fail || health_trip) begin
      valid_out <= 1'b0;
    end else if (word_done && (!valid_out || xfer)) begin
      data_out  <= shreg_p1;
      valid_out <= 1'b1;
    end else if (xfer) begin
      valid_out <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      health_state <= HEALTH_OK;
      health_fail  <= 1'b0;
    end else begin
      case (health_state)
        HEALTH_OK: begin
          if (health_trip) begin
            health_state <= HEALTH_FAIL;
            health_fail  <= 1'b1;
          end
        end
        HEALTH_FAIL: health_fail <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_entropy_source.sv
`timescale 1ns/1ps
// Directed bench for ro_entropy_source: raw_bit forced per sample for the packing,
// debias, handshake, health and enable cases, then an unforced free run.
module tb_ro_entropy_source;

  localparam int WORD_W     = 32;
  localparam int SAMPLE_DIV = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0;
  logic              vn_en = 1'b0;
  logic              rdy_in = 1'b0;
  logic [WORD_W-1:0] data_out, data_out64;
  logic              valid_out, valid_out64;
  logic              health_fail, health_fail64;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ro_entropy_source #(
    .NO_CHANNELS(4), .NO_STAGES(3), .INV_DELAY_ns(2),
    .SAMPLE_DIV(SAMPLE_DIV), .WORD_W(WORD_W), .REP_LIMIT(32)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .vn_en(vn_en), .rdy_in(rdy_in),
    .data_out(data_out), .valid_out(valid_out), .health_fail(health_fail)
  );

  ro_entropy_source #(
    .NO_CHANNELS(4), .NO_STAGES(3), .INV_DELAY_ns(2),
    .SAMPLE_DIV(SAMPLE_DIV), .WORD_W(WORD_W), .REP_LIMIT(64)
  ) dut64 (
    .clk(clk), .rst(rst), .en(en), .vn_en(vn_en), .rdy_in(rdy_in),
    .data_out(data_out64), .valid_out(valid_out64), .health_fail(health_fail64)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en  = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_raw(input bit sel, input bit b);
    if (!sel) begin
      if (b) force dut.raw_bit = 1'b1;
      else   force dut.raw_bit = 1'b0;
    end else begin
      if (b) force dut64.raw_bit = 1'b1;
      else   force dut64.raw_bit = 1'b0;
    end
  endtask

  // One raw sample per divider period, pattern bits taken MSB first and repeated.
  task automatic drive(input bit sel, input logic [31:0] pat, input int plen, input int n);
    for (int i = 0; i < n; i++) begin
      set_raw(sel, pat[plen - 1 - (i % plen)]);
      repeat (SAMPLE_DIV) step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      n_tests++;
      if (data_out !== '0) begin
        n_fail++; $display("FAIL reset_data: got %h expected 0", data_out);
      end
      n_tests++;
      if (valid_out !== 1'b0) begin
        n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_out);
      end
      n_tests++;
      if (health_fail !== 1'b0) begin
        n_fail++; $display("FAIL reset_health: got %b expected 0", health_fail);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_raw_word();
    do_reset();
    vn_en = 1'b0; rdy_in = 1'b0; en = 1'b1;
    drive(1'b0, 32'h2, 2, 32);
    n_tests++;
    if (valid_out !== 1'b0) begin
      n_fail++; $display("FAIL raw_valid_early: got %b expected 0", valid_out);
    end
    step();
    n_tests++;
    if (valid_out !== 1'b1) begin
      n_fail++; $display("FAIL raw_valid_rise: got %b expected 1", valid_out);
    end
    n_tests++;
    if (data_out !== 32'hAAAAAAAA) begin
      n_fail++; $display("FAIL raw_data: got %h expected aaaaaaaa", data_out);
    end
    rdy_in = 1'b1;
    step();
    n_tests++;
    if (valid_out !== 1'b0) begin
      n_fail++; $display("FAIL raw_xfer: got %b expected 0", valid_out);
    end
    rdy_in = 1'b0;
  endtask

  task automatic test_vn_word();
    do_reset();
    vn_en = 1'b1; rdy_in = 1'b0; en = 1'b1;
    drive(1'b0, 32'h9C, 8, 120);
    n_tests++;
    if (valid_out !== 1'b0) begin
      n_fail++; $display("FAIL vn_valid_early: got %b expected 0", valid_out);
    end
    drive(1'b0, 32'h9C, 8, 8);
    n_tests++;
    if (valid_out !== 1'b1) begin
      n_fail++; $display("FAIL vn_valid: got %b expected 1", valid_out);
    end
    n_tests++;
    if (data_out !== 32'hAAAAAAAA) begin
      n_fail++; $display("FAIL vn_data: got %h expected aaaaaaaa", data_out);
    end
    vn_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    vn_en = 1'b0; rdy_in = 1'b0; en = 1'b1;
    drive(1'b0, 32'h2, 2, 32);
    n_tests++;
    if (valid_out !== 1'b0) begin
      n_fail++; $display("FAIL bp_valid_early: got %b expected 0", valid_out);
    end
    drive(1'b0, 32'hC, 4, 32);
    n_tests++;
    if (valid_out !== 1'b1 || data_out !== 32'hAAAAAAAA) begin
      n_fail++; $display("FAIL bp_hold: got %b/%h expected 1/aaaaaaaa", valid_out, data_out);
    end
    drive(1'b0, 32'h1, 2, 32);
    n_tests++;
    if (data_out !== 32'hAAAAAAAA) begin
      n_fail++; $display("FAIL bp_drop: got %h expected aaaaaaaa", data_out);
    end
    rdy_in = 1'b1;
    step();
    n_tests++;
    if (valid_out !== 1'b1 || data_out !== 32'h55555555) begin
      n_fail++; $display("FAIL bp_same_cycle: got %b/%h expected 1/55555555", valid_out, data_out);
    end
    step();
    n_tests++;
    if (valid_out !== 1'b0) begin
      n_fail++; $display("FAIL bp_xfer: got %b expected 0", valid_out);
    end
    rdy_in = 1'b0;
  endtask

  task automatic test_health();
    do_reset();
    vn_en = 1'b0; rdy_in = 1'b1; en = 1'b1;
    drive(1'b0, 32'h1, 1, 31);
    n_tests++;
    if (health_fail !== 1'b0) begin
      n_fail++; $display("FAIL hl_early: got %b expected 0", health_fail);
    end
    drive(1'b0, 32'h1, 1, 1);
    n_tests++;
    if (health_fail !== 1'b1) begin
      n_fail++; $display("FAIL hl_trip: got %b expected 1", health_fail);
    end
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (valid_out !== 1'b0) begin
        n_fail++; $display("FAIL hl_valid: got %b expected 0", valid_out);
      end
      step();
    end
    en = 1'b0;
    repeat (3) step();
    en = 1'b1;
    repeat (3) step();
    n_tests++;
    if (health_fail !== 1'b1) begin
      n_fail++; $display("FAIL hl_sticky: got %b expected 1", health_fail);
    end
    do_reset();
    n_tests++;
    if (health_fail !== 1'b0) begin
      n_fail++; $display("FAIL hl_rst: got %b expected 0", health_fail);
    end
    rdy_in = 1'b0;
  endtask

  task automatic test_en_flush();
    do_reset();
    vn_en = 1'b0; rdy_in = 1'b0; en = 1'b1;
    drive(1'b1, 32'h2, 2, 10);
    en = 1'b0;
    step();
    step();
    en = 1'b1;
    drive(1'b1, 32'h1, 1, 31);
    n_tests++;
    if (valid_out64 !== 1'b0) begin
      n_fail++; $display("FAIL en_stale_count: got %b expected 0", valid_out64);
    end
    drive(1'b1, 32'h1, 1, 1);
    step();
    n_tests++;
    if (valid_out64 !== 1'b1 || data_out64 !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL en_word: got %b/%h expected 1/ffffffff", valid_out64, data_out64);
    end
    n_tests++;
    if (health_fail64 !== 1'b0) begin
      n_fail++; $display("FAIL en_health: got %b expected 0", health_fail64);
    end
  endtask

  task automatic test_free_run();
    int words;
    int cyc;
    release dut.raw_bit;
    release dut64.raw_bit;
    do_reset();
    repeat (2) step();
    vn_en = 1'b0; rdy_in = 1'b1; en = 1'b1;
    words = 0;
    cyc   = 0;
    while (words < 10 && cyc < 5000) begin
      step();
      cyc++;
      if (valid_out === 1'b1) words++;
    end
    n_tests++;
    if (words != 10) begin
      n_fail++; $display("FAIL free_words: got %0d expected 10 within budget", words);
    end
    n_tests++;
    if (health_fail !== 1'b0) begin
      n_fail++; $display("FAIL free_health: got %b expected 0", health_fail);
    end
    en = 1'b0;
    rdy_in = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    test_reset();
    test_raw_word();
    test_vn_word();
    test_back_to_back();
    test_health();
    test_en_flush();
    test_free_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
